// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: stall vector layout, NOP encodings, FSM states.
package if_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INS_W   = 32;
  localparam int STALL_W = 3;

  // Stall vector bit 0 is IF, bit 1 is ID, bit 2 is EX; IF/ID holds if ID or later stalls.
  localparam logic [STALL_W-1:0] STALL_IF        = 3'b001;
  localparam logic [STALL_W-1:0] STALL_MASK_IFID = 3'b110;

  localparam logic [ADDR_W-1:0] NOP_PC  = 32'h0000_0000;
  localparam logic [INS_W-1:0]  NOP_INS = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word fetches and buffers
// one returned instruction for the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_PC   = if_fetch_pkg::NOP_PC,
  parameter logic [31:0] NOP_INS  = if_fetch_pkg::NOP_INS,
  parameter int          STALL_W  = if_fetch_pkg::STALL_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall,
  input  logic               jump_en,
  input  logic [31:0]        jump_target,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ready,
  input  logic [31:0]        mem_data,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_ins,
  output logic               if_stall_req
);

  localparam logic [STALL_W-1:0] LP_MASK = STALL_W'(STALL_MASK_IFID);

  if_state_t   r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pending_pc;
  logic        r_kill;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_ins;

  logic        w_consume;

  assign w_consume = ((stall & LP_MASK) == '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= 32'h0000_0000;
      r_kill       <= 1'b0;
      r_buf_pc     <= NOP_PC;
      r_buf_ins    <= NOP_INS;
    end else if (rdy_in) begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          if (jump_en) r_fetch_pc <= jump_target;
        end
        REQ: begin
          if (mem_ready) begin
            if (jump_en) begin
              r_fetch_pc <= jump_target;
              r_kill     <= 1'b0;
            end else if (r_kill) begin
              r_fetch_pc <= r_pending_pc;
              r_kill     <= 1'b0;
            end else begin
              r_buf_pc  <= r_fetch_pc;
              r_buf_ins <= mem_data;
              r_state   <= HOLD;
            end
          end else if (jump_en) begin
            // Keep mem_addr stable; the redirect is applied once the in-flight word returns.
            r_pending_pc <= jump_target;
            r_kill       <= 1'b1;
          end
        end
        HOLD: begin
          if (jump_en) begin
            r_buf_pc   <= NOP_PC;
            r_buf_ins  <= NOP_INS;
            r_fetch_pc <= jump_target;
            r_state    <= REQ;
          end else if (w_consume) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req      = (r_state == REQ);
  assign mem_addr     = r_fetch_pc;
  assign if_stall_req = (r_state != HOLD);
  assign if_pc        = (r_state == HOLD) ? r_buf_pc  : NOP_PC;
  assign if_ins       = (r_state == HOLD) ? r_buf_ins : NOP_INS;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs change and outputs are checked on the falling edge.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [2:0]  stall;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic        if_stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .if_pc        (if_pc),
    .if_ins       (if_ins),
    .if_stall_req (if_stall_req)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  // Checks a REQ cycle: request high at addr, no valid instruction.
  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".stall_req"}, {31'd0, if_stall_req}, 32'd1);
    chk({tag, ".if_pc"}, if_pc, 32'h0000_0000);
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ".stall_req"}, {31'd0, if_stall_req}, 32'd0);
    chk({tag, ".if_pc"}, if_pc, pc);
    chk({tag, ".if_ins"}, if_ins, ins);
  endtask

  // A response with no request outstanding is a protocol violation.
  always @(posedge clk_in) begin
    if (rst_in && rdy_in && mem_ready) begin
      assert (mem_req === 1'b1) else begin
        n_fail++;
        $error("FAIL proto: mem_ready observed with mem_req %b expected 1", mem_req);
      end
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; stall = 3'b000; jump_en = 1'b0;
    jump_target = 32'h0; mem_ready = 1'b0; mem_data = 32'h0;
    cyc(); cyc();
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.stall_req", {31'd0, if_stall_req}, 32'd1);
    chk("rst.if_pc", if_pc, 32'h0);
    chk("rst.if_ins", if_ins, 32'h0000_0013);
    rst_in = 1'b1;

    // First fetch, 3-cycle memory
    cyc(); chk_req("f0a", 32'h0);
    cyc(); chk_req("f0b", 32'h0);
    cyc(); chk_req("f0c", 32'h0);
    mem_ready = 1'b1; mem_data = 32'h0050_0093;
    cyc(); mem_ready = 1'b0;
    chk_hold("f0hold", 32'h0, 32'h0050_0093);

    // Straight-line run, 1-cycle memory
    cyc(); chk_req("f4", 32'h4);
    mem_ready = 1'b1; mem_data = 32'h1111_0004;
    cyc(); mem_ready = 1'b0;
    chk_hold("f4hold", 32'h4, 32'h1111_0004);
    cyc(); chk_req("f8", 32'h8);
    mem_ready = 1'b1; mem_data = 32'h1111_0008;
    cyc(); mem_ready = 1'b0;
    chk_hold("f8hold", 32'h8, 32'h1111_0008);

    // IF/ID stall holds the buffer for 3 cycles
    stall = 3'b010;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_hold($sformatf("stall%0d", i), 32'h8, 32'h1111_0008);
    end
    stall = 3'b000;
    cyc(); chk_req("fC", 32'hC);
    mem_ready = 1'b1; mem_data = 32'h1111_000C;
    cyc(); mem_ready = 1'b0;
    chk_hold("fChold", 32'hC, 32'h1111_000C);
    cyc(); chk_req("f10", 32'h10);

    // Redirect while the 0x10 fetch is outstanding
    jump_en = 1'b1; jump_target = 32'h100;
    cyc(); jump_en = 1'b0;
    chk_req("kill1", 32'h10);
    cyc(); chk_req("kill2", 32'h10);
    mem_ready = 1'b1; mem_data = 32'hDEAD_0010;
    cyc(); mem_ready = 1'b0;
    chk_req("f100", 32'h100);
    mem_ready = 1'b1; mem_data = 32'h2222_0100;
    cyc(); mem_ready = 1'b0;
    chk_hold("f100hold", 32'h100, 32'h2222_0100);

    // Redirect coincident with mem_ready
    cyc(); chk_req("f104", 32'h104);
    mem_ready = 1'b1; mem_data = 32'hDEAD_0104; jump_en = 1'b1; jump_target = 32'h40;
    cyc(); mem_ready = 1'b0; jump_en = 1'b0;
    chk_req("f40", 32'h40);
    mem_ready = 1'b1; mem_data = 32'h3333_0040;
    cyc(); mem_ready = 1'b0;
    chk_hold("f40hold", 32'h40, 32'h3333_0040);

    // Redirect in HOLD wins over an IF/ID stall
    jump_en = 1'b1; jump_target = 32'h80; stall = 3'b110;
    cyc(); jump_en = 1'b0; stall = 3'b000;
    chk_req("f80", 32'h80);
    chk("f80.if_ins", if_ins, 32'h0000_0013);

    // rdy_in low freezes everything, including mem_ready and jump_en
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 1); mem_data = 32'hDEAD_0080;
      jump_en = (i == 3); jump_target = 32'h200;
      cyc(); chk_req($sformatf("frz%0d", i), 32'h80);
    end
    mem_ready = 1'b0; jump_en = 1'b0; rdy_in = 1'b1;
    cyc(); chk_req("thaw", 32'h80);

    // Asynchronous reset mid-fetch
    rst_in = 1'b0;
    #1;
    chk("arst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst.stall_req", {31'd0, if_stall_req}, 32'd1);
    chk("arst.mem_addr", mem_addr, 32'h0);
    cyc(); rst_in = 1'b1;
    cyc(); chk_req("rf0", 32'h0);
    mem_ready = 1'b1; mem_data = 32'h4444_0000;
    cyc(); mem_ready = 1'b0;
    chk_hold("rf0hold", 32'h0, 32'h4444_0000);

    // PC wraps from 0xFFFFFFFC to 0
    jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
    cyc(); jump_en = 1'b0;
    chk_req("fTop", 32'hFFFF_FFFC);
    mem_ready = 1'b1; mem_data = 32'h5555_FFFC;
    cyc(); mem_ready = 1'b0;
    chk_hold("fTophold", 32'hFFFF_FFFC, 32'h5555_FFFC);
    cyc(); chk_req("wrap", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues word fetches to the memory controller.
- Buffers one returned instruction and presents it as if_pc/if_ins.
- Raises a stall request to the stall controller whenever it has no valid instruction, so the controller can bubble IF/ID. Handles branch redirects from EX, including redirects that arrive while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_PC, 32'h0000_0000, if_pc value driven when no instruction is held
NOP_INS, 32'h0000_0013, if_ins value driven when no instruction is held (addi x0,x0,0)
STALL_W, 3, width of chip stall vector

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  chip ready; when low all state frozen
stall  in  STALL_W  chip stall vector from stall controller
jump_en  in  1  one-cycle redirect pulse from EX
jump_target  in  32  redirect PC (word aligned)
mem_req  out  1  fetch request, level, held until mem_ready
mem_addr  out  32  fetch word address, stable while mem_req high
mem_ready  in  1  one-cycle pulse: mem_data valid, request done
mem_data  in  32  fetched instruction word
if_pc  out  32  PC of held instruction, else NOP_PC
if_ins  out  32  held instruction, else NOP_INS
if_stall_req  out  1  high when no valid instruction held

Behaviour:
- Reset is asynchronous and active-low on rst_in.
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, kill=0, pending_pc=0.
  - Buffer registers are NOP_PC/NOP_INS, so if_pc=NOP_PC and if_ins=NOP_INS.
  - mem_req=0, mem_addr=RESET_PC, if_stall_req=1.
- rdy_in=0: no register changes. mem_ready, jump_en and stall are ignored that cycle. Outputs hold their values.
- States IDLE, REQ, HOLD. All outputs are decoded from registers only; there is no combinational input-to-output path.
  - mem_req=(state==REQ); mem_addr=fetch_pc.
  - if_stall_req=(state!=HOLD).
  - if_pc/if_ins = buffer when HOLD, else NOP_PC/NOP_INS.
- IDLE: goes to REQ on the first cycle with rdy_in=1. A jump_en in that same cycle loads fetch_pc<=jump_target.
- REQ (mem_req high):
  - mem_ready=1, kill=0, jump_en=0: buffer<={fetch_pc, mem_data}, go to HOLD.
  - mem_ready=1, jump_en=1: discard data, fetch_pc<=jump_target, kill<=0, stay in REQ. A new request starts the next cycle; mem_req stays high.
  - mem_ready=1, kill=1, jump_en=0: discard data, fetch_pc<=pending_pc, kill<=0, stay in REQ.
  - mem_ready=0, jump_en=1: pending_pc<=jump_target, kill<=1. fetch_pc is unchanged so mem_addr stays stable. A later jump overwrites pending_pc.
- HOLD, with consume = ((stall & STALL_MASK_IFID)==0):
  - jump_en=1: highest priority. Drop the buffer, fetch_pc<=jump_target, go to REQ. Flushing the wrong-path IF/ID contents is the stall controller's job via clear.
  - consume=1: fetch_pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go to REQ.
  - otherwise: stay in HOLD with the buffer unchanged.
- Latency: mem_ready at cycle t gives a valid if_pc/if_ins at t+1. Consume at t gives the next mem_req at t+1.
- Throughput: at most one instruction every 2 cycles plus memory latency.
- mem_ready outside REQ is a protocol error. It is ignored, and the bench flags it as an assertion.
- Reset mid-fetch abandons the outstanding request. The memory controller shares the reset.

Decomposition:
- Shared package (alongside the existing stall/NOP definitions):
  - STALL_MASK_IFID and STALL_IF constants.
  - NOP_PC and NOP_INS.
  - if_state_t enum {IDLE, REQ, HOLD}.
  - ADDR_W=32, INS_W=32.
- No sub-module is needed; the block is a single FSM plus datapath registers.

Test Plan:
- Reset, rdy_in=1, memory returns 32'h0050_0093 three cycles after the request -> mem_addr=0 held while mem_req high; one cycle after mem_ready, if_pc=0, if_ins=32'h0050_0093, if_stall_req=0.
- Straight-line run with stall=0 and 1-cycle memory -> mem_addr sequence 0,4,8,C; each instruction is held exactly one HOLD cycle.
- In HOLD at pc=8, apply stall&STALL_MASK_IFID≠0 for 3 cycles -> if_pc=8 stable, no mem_req; after release, the next mem_addr is C.
- With the request at 0x10 outstanding, pulse jump_en with target 0x100, then mem_ready two cycles later -> mem_addr stays 0x10 until mem_ready; data discarded; next mem_addr is 0x100 and if_pc is never 0x10.
- jump_en coincident with mem_ready in REQ (target 0x40), then a second case with jump_en in HOLD (target 0x80) -> data discarded and next request at 0x40; HOLD dropped and next request at 0x80.
- rdy_in low for 5 cycles mid-REQ with mem_ready pulsed during that window, then rst_in asserted mid-fetch -> no state change while rdy low; reset immediately forces mem_req=0, if_stall_req=1, and the next fetch is at RESET_PC.
